// File: rtl/wb_trace_if.sv
// Bundle between the dual-issue WB slots, the trace queue and the debug_wb_* trace port.
// master drives the retirement slots; slave is the queue side.
interface wb_trace_if;
  logic        i1_valid;
  logic [31:0] i1_pc;
  logic        i1_we;
  logic [4:0]  i1_waddr;
  logic [31:0] i1_wdata;
  logic        i2_valid;
  logic [31:0] i2_pc;
  logic        i2_we;
  logic [4:0]  i2_waddr;
  logic [31:0] i2_wdata;
  logic        stallreq_trace;
  logic        overflow;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output i1_valid, i1_pc, i1_we, i1_waddr, i1_wdata,
    output i2_valid, i2_pc, i2_we, i2_waddr, i2_wdata,
    input  stallreq_trace, overflow,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  i1_valid, i1_pc, i1_we, i1_waddr, i1_wdata,
    input  i2_valid, i2_pc, i2_we, i2_waddr, i2_wdata,
    output stallreq_trace, overflow,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_trace_queue.sv
// Serializes up to two retirements per cycle into a one-per-cycle in-order trace stream.
// Optional macro TRACE_WRITES_ONLY_EN: only enqueue slots that write a non-zero register.
module wb_trace_queue #(
  parameter int DEPTH = 8
) (
  input logic       clk,
  input logic       rst,
  wb_trace_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } entry_t;

  // Number of requested pushes that fit; the excess (youngest) is dropped.
  function automatic logic [1:0] sat_push(input logic [1:0] req, input logic [CW:0] space);
    if ({{(CW-1){1'b0}}, req} > space) return space[1:0];
    return req;
  endfunction

  entry_t        mem [DEPTH];
  logic [PW-1:0] head, tail, tail_inc;
  logic [CW-1:0] count, count_next;
  logic          overflow_q;

  logic          keep1, keep2;
  logic          pop;
  logic [1:0]    n_req, n_acc;
  logic [CW:0]   space;
  entry_t        e1, e2, first;

  logic [31:0]   dbg_pc_p1;
  logic [3:0]    dbg_wen_p1;
  logic [4:0]    dbg_wnum_p1;
  logic [31:0]   dbg_wdata_p1;

`ifdef TRACE_WRITES_ONLY_EN
  assign keep1 = bus.i1_valid & bus.i1_we & (bus.i1_waddr != 5'd0);
  assign keep2 = bus.i2_valid & bus.i2_we & (bus.i2_waddr != 5'd0);
`else
  assign keep1 = bus.i1_valid;
  assign keep2 = bus.i2_valid;
`endif

  assign e1 = '{pc: bus.i1_pc, we: bus.i1_we, waddr: bus.i1_waddr, wdata: bus.i1_wdata};
  assign e2 = '{pc: bus.i2_pc, we: bus.i2_we, waddr: bus.i2_waddr, wdata: bus.i2_wdata};

  // Stage p0: admission into the circular buffer
  always_comb begin
    pop        = (count != '0);
    n_req      = {1'b0, keep1} + {1'b0, keep2};
    space      = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, pop};
    n_acc      = sat_push(n_req, space);
    first      = keep1 ? e1 : e2;
    tail_inc   = tail + PW'(1);
    count_next = count + {{(CW-2){1'b0}}, n_acc} - {{(CW-1){1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (n_acc != 2'd0) mem[tail] <= first;
    if (n_acc == 2'd2) mem[tail_inc] <= e2;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) head <= head + PW'(1);
      tail  <= tail + PW'(n_acc);
      count <= count_next;
      if (n_acc != n_req) overflow_q <= 1'b1;
    end
  end

  // Stage p1: registered trace port, one head entry per edge
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_pc_p1    <= '0;
      dbg_wen_p1   <= '0;
      dbg_wnum_p1  <= '0;
      dbg_wdata_p1 <= '0;
    end else if (pop) begin
      dbg_pc_p1    <= mem[head].pc;
      dbg_wen_p1   <= {4{mem[head].we}};
      dbg_wnum_p1  <= mem[head].waddr;
      dbg_wdata_p1 <= mem[head].wdata;
    end else begin
      dbg_wen_p1   <= 4'b0000;
    end
  end

  assign bus.stallreq_trace    = (count >= CW'(DEPTH - 2));
  assign bus.overflow          = overflow_q;
  assign bus.debug_wb_pc       = dbg_pc_p1;
  assign bus.debug_wb_rf_wen   = dbg_wen_p1;
  assign bus.debug_wb_rf_wnum  = dbg_wnum_p1;
  assign bus.debug_wb_rf_wdata = dbg_wdata_p1;

endmodule

// File: tb/tb_wb_trace_queue.sv
// Directed bench for wb_trace_queue with a scoreboard model of the trace queue.
module tb_wb_trace_queue;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_trace_if bus();
  wb_trace_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  ent_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic        m_ovf  = 1'b0;
  logic [31:0] x_pc   = 0;
  logic [3:0]  x_wen  = 0;
  logic [4:0]  x_wnum = 0;
  logic [31:0] x_wdata = 0;
  int          peak;

  function automatic logic keeps(input logic v, input logic we, input logic [4:0] a);
`ifdef TRACE_WRITES_ONLY_EN
    return v && we && (a != 5'd0);
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic v1, input logic [31:0] p1, input logic w1,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic v2, input logic [31:0] p2, input logic w2,
                      input logic [4:0] a2, input logic [31:0] d2);
    ent_t e;
    rst = r;
    bus.i1_valid = v1; bus.i1_pc = p1; bus.i1_we = w1; bus.i1_waddr = a1; bus.i1_wdata = d1;
    bus.i2_valid = v2; bus.i2_pc = p2; bus.i2_we = w2; bus.i2_waddr = a2; bus.i2_wdata = d2;
    @(posedge clk);
    #1;
    if (r) begin
      sb.delete();
      m_ovf = 1'b0;
      x_pc = 0; x_wen = 0; x_wnum = 0; x_wdata = 0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        x_pc = e.pc; x_wen = {4{e.we}}; x_wnum = e.waddr; x_wdata = e.wdata;
      end else begin
        x_wen = 4'b0000;
      end
      if (keeps(v1, w1, a1)) begin
        if (sb.size() < DEPTH) sb.push_back('{p1, w1, a1, d1});
        else m_ovf = 1'b1;
      end
      if (keeps(v2, w2, a2)) begin
        if (sb.size() < DEPTH) sb.push_back('{p2, w2, a2, d2});
        else m_ovf = 1'b1;
      end
    end
    chk("pc",       bus.debug_wb_pc,       x_pc);
    chk("wen",      {28'd0, bus.debug_wb_rf_wen},  {28'd0, x_wen});
    chk("wnum",     {27'd0, bus.debug_wb_rf_wnum}, {27'd0, x_wnum});
    chk("wdata",    bus.debug_wb_rf_wdata, x_wdata);
    chk("stall",    {31'd0, bus.stallreq_trace}, {31'd0, 1'(sb.size() >= DEPTH - 2)});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    chk("count",    32'(dut.count),        32'(sb.size()));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pair(input logic [31:0] pc);
    step(1'b0, 1, pc, 1, 5'(pc[6:2]), pc ^ 32'h5A5A0000,
               1, pc + 4, 1, 5'(pc[6:2] + 1), pc ^ 32'hA5A50000);
  endtask

  initial begin
    logic s1, s2;
    logic [31:0] pc;

    // reset with both slots valid: inputs discarded
    step(1'b1, 1, 32'hDEAD0000, 1, 7, 32'h1, 1, 32'hDEAD0004, 1, 9, 32'h2);
    step(1'b1, 1, 32'hDEAD0008, 1, 7, 32'h3, 1, 32'hDEAD000C, 1, 9, 32'h4);
    idle(2);

    // single retirement
    step(1'b0, 1, 32'hBFC00000, 1, 8, 32'h1234, 0, 0, 0, 0, 0);
    idle(2);

    // pair ordering
    step(1'b0, 1, 32'h100, 1, 1, 32'hAA, 1, 32'h104, 1, 2, 32'hBB);
    idle(3);

    // slot 2 only
    step(1'b0, 0, 32'h111, 1, 4, 32'h11, 1, 32'h200, 1, 5, 32'h22);
    idle(2);

    // filter candidates: non-writing, write to r0, real write
    step(1'b0, 1, 32'h300, 0, 5, 32'h30, 0, 0, 0, 0, 0);
    step(1'b0, 0, 0, 0, 0, 0, 1, 32'h304, 1, 0, 32'h31);
    step(1'b0, 1, 32'h308, 1, 3, 32'h32, 0, 0, 0, 0, 0);
    idle(3);

    // backpressure with a CTRL model that freezes one edge late
    s1 = 0; s2 = 0; peak = 0; pc = 32'h1000;
    for (int i = 0; i < 30; i++) begin
      if (!s2) begin
        pair(pc);
        pc += 8;
      end else begin
        idle(1);
      end
      s2 = s1;
      s1 = bus.stallreq_trace;
      if (int'(dut.count) > peak) peak = int'(dut.count);
    end
    idle(DEPTH + 2);
    chk("peak_count", 32'(peak), 32'(DEPTH - 1));

    // overflow: stall ignored, youngest slots dropped
    pc = 32'h2000;
    for (int i = 0; i < 9; i++) begin
      pair(pc);
      pc += 8;
    end
    idle(DEPTH + 2);

    // reset clears sticky overflow and drops a partially filled queue
    pair(32'h3000);
    pair(32'h3008);
    step(1'b1, 1, 32'h4000, 1, 1, 1, 1, 32'h4004, 1, 2, 2);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
